// File: rtl/mem_pkg.sv
// Shared types and sizes for the load/store sequencer.
// Sequencer states plus memory geometry.
package mem_pkg;

  localparam int MEM_W  = 8;
  localparam int MEM_A  = 8;
  localparam int HALF_W = 2 * MEM_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2,
    RESP = 2'd3
  } state_e;

endpackage

// File: rtl/mem_access_unit.sv
// Byte/halfword load-store sequencer for a byte-wide memory.
// Halfwords become two little-endian byte accesses.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int W = MEM_W,
  parameter int A = MEM_A
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           ReqValid,
  output logic           ReqReady,
  input  logic           ReqWrite,
  input  logic           ReqHalf,
  input  logic [A-1:0]   ReqAddr,
  input  logic [2*W-1:0] ReqWData,
  output logic           RespValid,
  output logic [2*W-1:0] RespRData,
  output logic [A-1:0]   MemAddr,
  output logic           MemWriteEn,
  output logic [W-1:0]   MemWData,
  input  logic [W-1:0]   MemRData
);

  state_e         state_q;
  logic [A-1:0]   addr_q;
  logic [2*W-1:0] wdata_q;
  logic           write_q;
  logic           half_q;
  logic [2*W-1:0] rdata_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      half_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (ReqValid) begin
            addr_q  <= ReqAddr;
            wdata_q <= ReqWData;
            write_q <= ReqWrite;
            half_q  <= ReqHalf;
            // Clearing here zero-extends byte loads.
            rdata_q <= '0;
            state_q <= ACC0;
          end
        end
        ACC0: begin
          if (!write_q)
            rdata_q[W-1:0] <= MemRData;
          state_q <= half_q ? ACC1 : RESP;
        end
        ACC1: begin
          if (!write_q)
            rdata_q[2*W-1:W] <= MemRData;
          state_q <= RESP;
        end
        RESP: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    MemAddr    = addr_q;
    MemWriteEn = 1'b0;
    MemWData   = '0;
    RespValid  = 1'b0;
    RespRData  = '0;
    ReqReady   = 1'b0;
    unique case (1'b1)
      (state_q == IDLE): begin
        ReqReady = !Reset;
      end
      (state_q == ACC0): begin
        MemWriteEn = write_q && !Reset;
        MemWData   = write_q ? wdata_q[W-1:0] : '0;
      end
      (state_q == ACC1): begin
        MemAddr    = addr_q + A'(1);
        MemWriteEn = write_q && !Reset;
        MemWData   = write_q ? wdata_q[2*W-1:W] : '0;
      end
      (state_q == RESP): begin
        RespValid = 1'b1;
        RespRData = write_q ? '0 : rdata_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed cases plus random ops
// against a reference byte array.
module tb_mem_access_unit;
  import mem_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        ReqValid;
  logic        ReqReady;
  logic        ReqWrite;
  logic        ReqHalf;
  logic [7:0]  ReqAddr;
  logic [15:0] ReqWData;
  logic        RespValid;
  logic [15:0] RespRData;
  logic [7:0]  MemAddr;
  logic        MemWriteEn;
  logic [7:0]  MemWData;
  logic [7:0]  MemRData;

  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  logic       bd_we;
  logic [7:0] bd_a;
  logic [7:0] bd_d;
  int         wcount;
  int         rcount;
  int         errors;
  int         checks;

  mem_access_unit #(.W(8), .A(8)) dut (
    .Clk(Clk),
    .Reset(Reset),
    .ReqValid(ReqValid),
    .ReqReady(ReqReady),
    .ReqWrite(ReqWrite),
    .ReqHalf(ReqHalf),
    .ReqAddr(ReqAddr),
    .ReqWData(ReqWData),
    .RespValid(RespValid),
    .RespRData(RespRData),
    .MemAddr(MemAddr),
    .MemWriteEn(MemWriteEn),
    .MemWData(MemWData),
    .MemRData(MemRData)
  );

  always #5 Clk = ~Clk;

  assign MemRData = mem[MemAddr];

  always @(posedge Clk) begin
    if (bd_we)
      mem[bd_a] <= bd_d;
    else if (MemWriteEn)
      mem[MemAddr] <= MemWData;
    if (MemWriteEn)
      wcount++;
    if (RespValid)
      rcount++;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic bd(input logic [7:0] a, input logic [7:0] d);
    bd_we = 1'b1;
    bd_a  = a;
    bd_d  = d;
    tick();
    bd_we = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic do_op(input logic wr, input logic hf,
                       input logic [7:0] a, input logic [15:0] wd);
    int n;
    int w0;
    int r0;
    logic [15:0] exp;
    logic [7:0]  a1;
    a1 = a + 8'd1;
    if (wr)
      exp = 16'h0;
    else if (hf)
      exp = {ref_mem[a1], ref_mem[a]};
    else
      exp = {8'h00, ref_mem[a]};
    ReqValid = 1'b1;
    ReqWrite = wr;
    ReqHalf  = hf;
    ReqAddr  = a;
    ReqWData = wd;
    n = 0;
    while (!ReqReady && n < 10) begin
      tick();
      n++;
    end
    chk("accept", 32'(ReqReady), 1);
    if (!ReqReady) begin
      ReqValid = 1'b0;
      return;
    end
    w0 = wcount;
    r0 = rcount;
    tick();
    ReqValid = 1'b0;
    n = 1;
    while (!RespValid && n < 6) begin
      tick();
      n++;
    end
    chk("latency", n, hf ? 3 : 2);
    chk("rdata", 32'(RespRData), 32'(exp));
    if (wr) begin
      ref_mem[a] = wd[7:0];
      if (hf)
        ref_mem[a1] = wd[15:8];
    end
    chk("wr_cnt", wcount - w0, wr ? (hf ? 2 : 1) : 0);
    chk("mem_lo", 32'(mem[a]), 32'(ref_mem[a]));
    if (hf)
      chk("mem_hi", 32'(mem[a1]), 32'(ref_mem[a1]));
    tick();
    chk("resp_once", rcount - r0, 1);
    chk("resp_low", 32'(RespValid), 0);
  endtask

  initial begin
    int w0;
    int r0;
    errors   = 0;
    checks   = 0;
    wcount   = 0;
    rcount   = 0;
    Reset    = 1'b1;
    ReqValid = 1'b0;
    ReqWrite = 1'b0;
    ReqHalf  = 1'b0;
    ReqAddr  = 8'h00;
    ReqWData = 16'h0;
    bd_we    = 1'b0;
    bd_a     = 8'h00;
    bd_d     = 8'h00;
    tick();
    tick();
    chk("rst_ready", 32'(ReqReady), 0);
    chk("rst_we", 32'(MemWriteEn), 0);
    Reset = 1'b0;
    tick();
    chk("idle_ready", 32'(ReqReady), 1);
    chk("idle_resp", 32'(RespValid), 0);
    chk("idle_rdata", 32'(RespRData), 0);
    chk("idle_addr", 32'(MemAddr), 0);
    chk("idle_wdata", 32'(MemWData), 0);

    for (int i = 0; i < 256; i++)
      bd(8'(i), 8'($urandom));
    bd(8'h20, 8'hCD);
    bd(8'h21, 8'hAB);
    bd(8'h30, 8'hFF);

    do_op(1'b1, 1'b0, 8'h10, 16'h00A5);
    chk("bst_mem", 32'(mem[8'h10]), 32'hA5);
    do_op(1'b1, 1'b1, 8'hFF, 16'h1234);
    chk("wrap_lo", 32'(mem[8'hFF]), 32'h34);
    chk("wrap_hi", 32'(mem[8'h00]), 32'h12);
    do_op(1'b0, 1'b1, 8'h20, 16'h0);
    do_op(1'b0, 1'b0, 8'h30, 16'h0);
    do_op(1'b0, 1'b1, 8'hFF, 16'h0);

    // Back-to-back with ReqValid held high
    w0 = wcount;
    r0 = rcount;
    ReqValid = 1'b1;
    ReqWrite = 1'b1;
    ReqHalf  = 1'b0;
    ReqAddr  = 8'h60;
    ReqWData = 16'h0055;
    chk("b2b_rdy0", 32'(ReqReady), 1);
    tick();
    chk("b2b_acc0", 32'(ReqReady), 0);
    ReqWrite = 1'b0;
    tick();
    chk("b2b_resp", 32'(ReqReady), 0);
    chk("b2b_rv1", 32'(RespValid), 1);
    tick();
    chk("b2b_idle", 32'(ReqReady), 1);
    chk("b2b_rvlo", 32'(RespValid), 0);
    tick();
    ReqValid = 1'b0;
    chk("b2b_busy", 32'(ReqReady), 0);
    tick();
    chk("b2b_rv2", 32'(RespValid), 1);
    chk("b2b_rd", 32'(RespRData), 32'h0055);
    tick();
    tick();
    chk("b2b_nresp", rcount - r0, 2);
    chk("b2b_nwr", wcount - w0, 1);
    ref_mem[8'h60] = 8'h55;

    // Reset during the second byte of a halfword store
    r0 = rcount;
    ReqValid = 1'b1;
    ReqWrite = 1'b1;
    ReqHalf  = 1'b1;
    ReqAddr  = 8'h40;
    ReqWData = 16'hBEEF;
    tick();
    ReqValid = 1'b0;
    tick();
    Reset = 1'b1;
    #1;
    chk("rst_we_kill", 32'(MemWriteEn), 0);
    tick();
    Reset = 1'b0;
    #1;
    chk("rst_rdy", 32'(ReqReady), 1);
    ref_mem[8'h40] = 8'hEF;
    chk("rst_lo", 32'(mem[8'h40]), 32'hEF);
    chk("rst_hi", 32'(mem[8'h41]), 32'(ref_mem[8'h41]));
    tick();
    tick();
    chk("rst_noresp", rcount - r0, 0);

    for (int i = 0; i < 40; i++) begin
      logic [7:0] ra;
      ra = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      do_op(1'($urandom), 1'($urandom), ra, 16'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Load/store sequencer between the datapath and the single-port byte-wide data memory. Accepts byte or halfword load/store requests over a valid/ready handshake. Splits each halfword into two consecutive byte accesses, little-endian, one access per cycle. Drives the memory's address/write-enable/write-data pins and assembles read data from its combinational read port.

Parameters:
W, 8, memory data width (bits per entry)
A, 8, memory address width (2**A entries)

Ports:
Clk  input  1  clock
Reset  input  1  synchronous, active-high reset
ReqValid  input  1  request present
ReqReady  output  1  unit can accept a request this cycle
ReqWrite  input  1  1=store, 0=load
ReqHalf  input  1  1=halfword (2 bytes), 0=byte
ReqAddr  input  A  byte address of low byte
ReqWData  input  2W  store data; bits [W-1:0] go to the low address
RespValid  output  1  one-cycle completion pulse (loads and stores)
RespRData  output  2W  load result, valid while RespValid=1
MemAddr  output  A  to memory address
MemWriteEn  output  1  to memory write enable
MemWData  output  W  to memory write data
MemRData  input  W  from memory read data (combinational on MemAddr)

Behaviour:
- Reset is Clk, synchronous, active-high.
- States: IDLE, ACC0, ACC1, RESP. Reset -> IDLE. Latched regs (addr, wdata, write, half, rdata) -> 0 on reset.
- ReqReady = 1 only in IDLE and not Reset. Accept on ReqValid && ReqReady at posedge: latch ReqAddr/ReqWData/ReqWrite/ReqHalf, go to ACC0. ReqValid outside IDLE is ignored; no queuing.
- ACC0: MemAddr = addr. Store: MemWriteEn=1, MemWData = wdata[W-1:0]. Load: capture MemRData into rdata[W-1:0] at the closing edge. Next state is ACC1 if half, else RESP.
- ACC1: MemAddr = addr+1 mod 2**A (0xFF wraps to 0x00). Store: MemWriteEn=1, MemWData = wdata[2W-1:W]. Load: capture into rdata[2W-1:W]. Next state RESP.
- RESP: RespValid=1 for exactly one cycle, then IDLE. RespRData = rdata.
  - Byte load: upper W bits are zero.
  - Store: RespRData = 0.
- Outside ACC0/ACC1:
  - MemWriteEn = 0.
  - MemWData = 0.
  - MemAddr = latched addr (0 after reset).
- MemWriteEn is forced to 0 combinationally while Reset=1.
- RespValid=0 and RespRData=0 whenever not in RESP.
- Latency from accept edge: byte = RespValid 2 cycles later; halfword = 3 cycles later.
- Maximum throughput: one byte op per 3 cycles, one halfword op per 4 cycles. The next request is accepted in the IDLE cycle after RESP.
- Reset mid-operation (any state): return to IDLE next edge and drop the request.
  - No RespValid for the dropped request.
  - No further memory writes.
  - A byte already written in ACC0 stays written; no rollback.
- Memory reads are combinational. Captured data is the value at MemAddr in the same cycle.
- A read and a write are never issued in the same cycle.

Decomposition:
- Shared package mem_pkg holds:
  - state enum (IDLE, ACC0, ACC1, RESP) as 2-bit logic
  - localparams MEM_W=8, MEM_A=8
  - halfword width constant 2*MEM_W
- No sub-module. The FSM and datapath fit one module; the address incrementer is inline (A-bit add, carry discarded).

Test Plan:
- Byte store: Req write, byte, addr 0x10, data 0x00A5.
  - Response: MemWriteEn=1 for one cycle with MemAddr=0x10, MemWData=0xA5.
  - RespValid 2 cycles after accept; memory[0x10]=0xA5.
- Halfword store with wrap: addr 0xFF, data 0x1234.
  - Response: writes 0x34 at 0xFF, then 0x12 at 0x00 on consecutive cycles.
  - RespValid 3 cycles after accept.
- Halfword load: memory[0x20]=0xCD, [0x21]=0xAB; load half at 0x20.
  - Response: no MemWriteEn; RespRData=0xABCD with RespValid 3 cycles after accept.
- Byte load zero-extend: memory[0x30]=0xFF.
  - Response: RespRData=0x00FF.
- Busy/back-to-back: ReqValid held high continuously with two requests.
  - Response: ReqReady=0 during ACC0..RESP; the second request is accepted only in the IDLE cycle after RESP; no request is lost or duplicated.
- Reset mid-op: halfword store 0xBEEF at 0x40, with Reset asserted in ACC1.
  - Response: memory[0x40]=0xEF, memory[0x41] unchanged, no RespValid, ReqReady=1 the cycle after Reset deasserts.
